// File: rtl/dpram_port_arbiter.sv
// Two-requester front end for a dual-port RAM: serializes same-address hazards
// round-robin, returns registered read data and counts collisions.
module dpram_port_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              gnt_a,
   output logic              rvalid_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              gnt_b,
   output logic              rvalid_b,
   output logic [DATA_W-1:0] rdata_b,
   output logic [DATA_W-1:0] ram_ip_a,
   output logic [DATA_W-1:0] ram_ip_b,
   output logic [ADDR_W-1:0] ram_add_a,
   output logic [ADDR_W-1:0] ram_add_b,
   output logic              ram_wr_a,
   output logic              ram_wr_b,
   input  logic [DATA_W-1:0] ram_q_a,
   input  logic [DATA_W-1:0] ram_q_b,
   output logic [CNT_W-1:0]  coll_cnt
);

   typedef enum logic {PrioA, PrioB} prio_e;

   prio_e             prio_q, prio_d;
   logic              conflict;
   logic              rvalid_a_q, rvalid_b_q;
   logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
   logic [CNT_W-1:0]  coll_q, coll_d;

   always_comb begin
      conflict = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);

      // Grants are forced low during reset so the RAM never sees a stray write.
      gnt_a = rst_n & req_a & (~conflict | (prio_q == PrioA));
      gnt_b = rst_n & req_b & (~conflict | (prio_q == PrioB));

      ram_add_a = addr_a;
      ram_add_b = addr_b;
      ram_ip_a  = wdata_a;
      ram_ip_b  = wdata_b;
      ram_wr_a  = gnt_a & we_a;
      ram_wr_b  = gnt_b & we_b;

      prio_d = prio_q;
      coll_d = coll_q;
      if (conflict) begin
         // Hand priority to the loser so it wins the next conflict.
         prio_d = (prio_q == PrioA) ? PrioB : PrioA;
         if (~&coll_q) coll_d = coll_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q     <= PrioA;
         coll_q     <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
      end else begin
         prio_q     <= prio_d;
         coll_q     <= coll_d;
         rvalid_a_q <= gnt_a & ~we_a;
         rvalid_b_q <= gnt_b & ~we_b;
         if (rvalid_a_q) rdata_a_q <= ram_q_a;
         if (rvalid_b_q) rdata_b_q <= ram_q_b;
      end
   end

   // RAM data is live during the valid cycle; afterwards the captured copy is held.
   assign rvalid_a = rvalid_a_q;
   assign rvalid_b = rvalid_b_q;
   assign rdata_a  = rvalid_a_q ? ram_q_a : rdata_a_q;
   assign rdata_b  = rvalid_b_q ? ram_q_b : rdata_b_q;
   assign coll_cnt = coll_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural write-first dual-port RAM.
module tb_dpram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_a, we_a, req_b, we_b;
   logic [5:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [7:0] rdata_a, rdata_b;
   logic [7:0] ram_ip_a, ram_ip_b, ram_q_a, ram_q_b;
   logic [5:0] ram_add_a, ram_add_b;
   logic       ram_wr_a, ram_wr_b;
   logic [15:0] coll_cnt;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   dpram_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
      .ram_ip_a(ram_ip_a), .ram_ip_b(ram_ip_b),
      .ram_add_a(ram_add_a), .ram_add_b(ram_add_b),
      .ram_wr_a(ram_wr_a), .ram_wr_b(ram_wr_b),
      .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
      .coll_cnt(coll_cnt)
   );

   logic [7:0] mem [64];
   always_ff @(posedge clk) begin
      if (ram_wr_a) mem[ram_add_a] <= ram_ip_a;
      if (ram_wr_b) mem[ram_add_b] <= ram_ip_b;
      ram_q_a <= ram_wr_a ? ram_ip_a : mem[ram_add_a];
      ram_q_b <= ram_wr_b ? ram_ip_b : mem[ram_add_b];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_a(input logic r, input logic w, input logic [5:0] ad, input logic [7:0] d);
      req_a = r; we_a = w; addr_a = ad; wdata_a = d;
   endtask

   task automatic drive_b(input logic r, input logic w, input logic [5:0] ad, input logic [7:0] d);
      req_b = r; we_b = w; addr_b = ad; wdata_b = d;
   endtask

   // Advance one clock; inputs are changed and outputs sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive_a(1'b1, 1'b1, 6'd0, 8'h00);
      drive_b(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      chk("rst_gnt_a", gnt_a, 0);
      chk("rst_ram_wr_a", ram_wr_a, 0);
      chk("rst_rvalid_a", rvalid_a, 0);
      chk("rst_rdata_a", rdata_a, 0);
      chk("rst_coll", coll_cnt, 0);
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_gnt_b", gnt_b, 0);
      chk("idle_ram_wr_b", ram_wr_b, 0);

      // Disjoint writes
      drive_a(1'b1, 1'b1, 6'd0, 8'h01);
      drive_b(1'b1, 1'b1, 6'd1, 8'h12);
      #1;
      chk("wr2_gnt_a", gnt_a, 1);
      chk("wr2_gnt_b", gnt_b, 1);
      chk("wr2_ram_wr_a", ram_wr_a, 1);
      step();
      chk("wr2_coll", coll_cnt, 0);
      chk("wr2_no_rvalid_a", rvalid_a, 0);
      drive_b(1'b0, 1'b0, 6'd0, 8'h00);
      drive_a(1'b1, 1'b0, 6'd1, 8'h00);
      #1;
      chk("rd1_gnt_a", gnt_a, 1);
      chk("rd1_ram_wr_a", ram_wr_a, 0);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      chk("rd1_rvalid_a", rvalid_a, 1);
      chk("rd1_rdata_a", rdata_a, 8'h12);
      step();
      chk("rd1_rvalid_drop", rvalid_a, 0);
      chk("rd1_rdata_hold", rdata_a, 8'h12);

      // First conflict: A has priority
      drive_a(1'b1, 1'b1, 6'd2, 8'h03);
      drive_b(1'b1, 1'b1, 6'd2, 8'h13);
      #1;
      chk("c1_gnt_a", gnt_a, 1);
      chk("c1_gnt_b", gnt_b, 0);
      step();
      chk("c1_coll", coll_cnt, 1);
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      chk("c1_retry_gnt_b", gnt_b, 1);
      step();
      drive_b(1'b0, 1'b0, 6'd0, 8'h00);
      drive_a(1'b1, 1'b0, 6'd2, 8'h00);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      chk("c1_rdata_a", rdata_a, 8'h13);

      // Second conflict: B now has priority
      drive_a(1'b1, 1'b1, 6'd3, 8'h04);
      drive_b(1'b1, 1'b1, 6'd3, 8'h14);
      #1;
      chk("c2_gnt_a", gnt_a, 0);
      chk("c2_gnt_b", gnt_b, 1);
      step();
      chk("c2_coll", coll_cnt, 2);
      drive_b(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      chk("c2_retry_gnt_a", gnt_a, 1);
      step();

      // Preload addr5 = 06, then A read vs B write (A has priority again)
      drive_a(1'b1, 1'b1, 6'd5, 8'h06);
      step();
      drive_a(1'b1, 1'b0, 6'd5, 8'h00);
      drive_b(1'b1, 1'b1, 6'd5, 8'h09);
      #1;
      chk("rw_gnt_a", gnt_a, 1);
      chk("rw_gnt_b", gnt_b, 0);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      chk("rw_rvalid_a", rvalid_a, 1);
      chk("rw_rdata_a", rdata_a, 8'h06);
      chk("rw_coll", coll_cnt, 3);
      chk("rw_gnt_b_retry", gnt_b, 1);
      step();
      chk("rw_no_rvalid_b", rvalid_b, 0);
      drive_b(1'b1, 1'b1, 6'd4, 8'h05);
      step();

      // Read-read same address is not a conflict
      drive_a(1'b1, 1'b0, 6'd4, 8'h00);
      drive_b(1'b1, 1'b0, 6'd4, 8'h00);
      #1;
      chk("rr_gnt_a", gnt_a, 1);
      chk("rr_gnt_b", gnt_b, 1);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      drive_b(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      chk("rr_rvalid_a", rvalid_a, 1);
      chk("rr_rvalid_b", rvalid_b, 1);
      chk("rr_rdata_a", rdata_a, 8'h05);
      chk("rr_rdata_b", rdata_b, 8'h05);
      chk("rr_coll", coll_cnt, 3);

      // Reset during a pending read
      drive_a(1'b1, 1'b0, 6'd4, 8'h00);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      chk("mid_rvalid_pre", rvalid_a, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rvalid_clr", rvalid_a, 0);
      chk("mid_coll_clr", coll_cnt, 0);
      rst_n = 1'b1;

      // Saturation: priority is back to A after reset
      drive_a(1'b1, 1'b1, 6'd6, 8'h07);
      drive_b(1'b1, 1'b1, 6'd6, 8'h17);
      #1;
      chk("sat_first_gnt_a", gnt_a, 1);
      step();
      for (int i = 0; i < 65533; i++) step();
      chk("sat_fffe", coll_cnt, 16'hFFFE);
      chk("sat_even_gnt_a", gnt_a, 1);
      chk("sat_even_gnt_b", gnt_b, 0);
      step();
      chk("sat_ffff", coll_cnt, 16'hFFFF);
      for (int i = 0; i < 5; i++) step();
      chk("sat_hold", coll_cnt, 16'hFFFF);
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      drive_b(1'b0, 1'b0, 6'd0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
